// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and width helper for the N-client cacheline memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  // Grant index width; a single client still gets a 1-bit index.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_picker.sv
// Combinational winner selection: rotate requests to the search start,
// priority-encode the lowest set bit, then rotate the index back.
module arb_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  input  logic          rr,
  output logic [GW-1:0] winner,
  output logic          any_req
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [GW-1:0]  start;
  logic [GW-1:0]  pos;
  logic [31:0]    nxt;
  logic [31:0]    sum;

  always_comb begin
    nxt   = 32'(last) + 32'd1;
    start = (rr && (nxt < 32'(N))) ? GW'(nxt) : '0;
    dbl   = {req, req};
    rot   = N'(dbl >> start);
    pos   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) pos = GW'(i);
    end
    sum     = 32'(start) + 32'(pos);
    winner  = (sum >= 32'(N)) ? GW'(sum - 32'(N)) : GW'(sum);
    any_req = |req;
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-client line arbiter in front of the single cacheline adaptor port:
// latches one winning request, holds it until mem_resp, routes the response back.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLIENTS-1:0]                 cl_read,
  input  logic [NUM_CLIENTS-1:0]                 cl_write,
  input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS-1:0][LINE_WIDTH-1:0] cl_wdata,
  output logic [LINE_WIDTH-1:0]                  cl_rdata,
  output logic [NUM_CLIENTS-1:0]                 cl_resp,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [LINE_WIDTH-1:0]                  mem_wdata,
  input  logic [LINE_WIDTH-1:0]                  mem_rdata,
  input  logic                                   mem_resp,
  output logic                                   grant_valid,
  output logic [grant_w(NUM_CLIENTS)-1:0]        grant_id
);

  localparam int unsigned GW = grant_w(NUM_CLIENTS);

  arb_state_e            state_q, state_d;
  arb_op_e               op_q, op_d;
  logic [GW-1:0]         gid_q, gid_d;
  logic [GW-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [GW-1:0]          winner;
  logic                   any_req;

  assign req = cl_read | cl_write;

  arb_picker #(
    .N  (NUM_CLIENTS),
    .GW (GW)
  ) u_picker (
    .req     (req),
    .last    (last_q),
    .rr      (ROUND_ROBIN != 0),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      gid_q   <= '0;
      last_q  <= GW'(NUM_CLIENTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, request latch and same-cycle response routing.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    gid_d    = gid_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cl_resp  = '0;
    cl_rdata = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          gid_d   = winner;
          op_d    = cl_write[winner] ? OP_WRITE : OP_READ;
          addr_d  = cl_addr[winner];
          wdata_d = cl_wdata[winner];
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d         = IDLE;
          cl_resp[gid_q]  = 1'b1;
          cl_rdata        = mem_rdata;
          if (ROUND_ROBIN != 0) last_d = gid_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read    = (state_q == BUSY) && (op_q == OP_READ);
  assign mem_write   = (state_q == BUSY) && (op_q == OP_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant_valid = (state_q == BUSY);
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a 4-client round-robin instance and a 2-client
// fixed-priority instance, each checked every cycle against a transaction model.
module tb_mem_arbiter_n;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]         a_read, a_write, a_resp;
  logic [3:0][AW-1:0] a_addr;
  logic [3:0][LW-1:0] a_wdata;
  logic [LW-1:0]      a_rdata, a_mwdata, a_memrdata;
  logic [AW-1:0]      a_maddr;
  logic               a_mread, a_mwrite, a_memresp, a_gv;
  logic [1:0]         a_gid;

  logic [1:0]         b_read, b_write, b_resp;
  logic [1:0][AW-1:0] b_addr;
  logic [1:0][LW-1:0] b_wdata;
  logic [LW-1:0]      b_rdata, b_mwdata, b_memrdata;
  logic [AW-1:0]      b_maddr;
  logic               b_mread, b_mwrite, b_memresp, b_gv;
  logic [0:0]         b_gid;

  mem_arbiter_n #(.NUM_CLIENTS(4), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(1)) u_a (
    .clk(clk), .rst(rst), .cl_read(a_read), .cl_write(a_write), .cl_addr(a_addr),
    .cl_wdata(a_wdata), .cl_rdata(a_rdata), .cl_resp(a_resp), .mem_read(a_mread),
    .mem_write(a_mwrite), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_memrdata),
    .mem_resp(a_memresp), .grant_valid(a_gv), .grant_id(a_gid)
  );

  mem_arbiter_n #(.NUM_CLIENTS(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(0)) u_b (
    .clk(clk), .rst(rst), .cl_read(b_read), .cl_write(b_write), .cl_addr(b_addr),
    .cl_wdata(b_wdata), .cl_rdata(b_rdata), .cl_resp(b_resp), .mem_read(b_mread),
    .mem_write(b_mwrite), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_memrdata),
    .mem_resp(b_memresp), .grant_valid(b_gv), .grant_id(b_gid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding line op per arbiter.
  int          nc[2]     = '{4, 2};
  bit          rrm[2]    = '{1'b1, 1'b0};
  bit          m_busy[2] = '{1'b0, 1'b0};
  bit          m_wr[2]   = '{1'b0, 1'b0};
  int          m_gid[2]  = '{0, 0};
  int          m_last[2] = '{3, 1};
  logic [31:0] m_addr[2];
  logic [63:0] m_wd[2];

  function automatic int pick(int n, bit rr, int last, logic [3:0] req);
    int c;
    for (int k = 0; k < n; k++) begin
      c = rr ? (last + 1 + k) % n : k;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(int d, logic r, logic [3:0] rd, logic [3:0] wr,
                            logic [3:0][31:0] ad, logic [3:0][63:0] wd, logic mresp);
    int w;
    if (r) begin
      m_busy[d] = 1'b0;
      m_last[d] = nc[d] - 1;
    end else if (!m_busy[d]) begin
      w = pick(nc[d], rrm[d], m_last[d], rd | wr);
      if (w >= 0) begin
        m_busy[d] = 1'b1;
        m_gid[d]  = w;
        m_wr[d]   = wr[w];
        m_addr[d] = ad[w];
        m_wd[d]   = wd[w];
      end
    end else if (mresp) begin
      m_busy[d] = 1'b0;
      if (rrm[d]) m_last[d] = m_gid[d];
    end
  endtask

  task automatic compare(int d, logic mresp, logic [63:0] mrdata, logic [3:0] resp,
                         logic [63:0] rdata, logic mr, logic mw, logic [31:0] maddr,
                         logic [63:0] mwd, logic gv, logic [1:0] gid);
    logic [3:0] er;
    logic       fire;
    string      t;
    t    = (d == 0) ? "a." : "b.";
    fire = m_busy[d] && (mresp === 1'b1);
    er   = fire ? 4'(1 << m_gid[d]) : 4'b0;
    chk({t, "cl_resp"}, 64'(resp), 64'(er));
    chk({t, "cl_rdata"}, rdata, fire ? mrdata : 64'b0);
    chk({t, "mem_read"}, 64'(mr), 64'(m_busy[d] && !m_wr[d]));
    chk({t, "mem_write"}, 64'(mw), 64'(m_busy[d] && m_wr[d]));
    chk({t, "grant_valid"}, 64'(gv), 64'(m_busy[d]));
    if (m_busy[d]) begin
      chk({t, "mem_addr"}, 64'(maddr), 64'(m_addr[d]));
      chk({t, "mem_wdata"}, mwd, m_wd[d]);
      chk({t, "grant_id"}, 64'(gid), 64'(m_gid[d]));
    end
  endtask

  always @(posedge clk or posedge rst) begin
    model_step(0, rst, a_read, a_write, a_addr, a_wdata, a_memresp);
    model_step(1, rst, {2'b0, b_read}, {2'b0, b_write}, {64'b0, b_addr},
               {128'b0, b_wdata}, b_memresp);
  end

  always @(negedge clk) begin
    compare(0, a_memresp, a_memrdata, a_resp, a_rdata, a_mread, a_mwrite, a_maddr,
            a_mwdata, a_gv, a_gid);
    compare(1, b_memresp, b_memrdata, {2'b0, b_resp}, b_rdata, b_mread, b_mwrite, b_maddr,
            b_mwdata, b_gv, {1'b0, b_gid});
  end

  // Grant-order log, read-cycle count and reassertion-gap monitor.
  int cyc = 0;
  int last_resp_cyc = -1;
  bit gap_en = 1'b0;
  bit prev_act = 1'b0;
  int a_mrd_cnt = 0;
  int a_order[$];
  int b_order[$];

  always @(negedge clk) begin
    cyc++;
    if (gap_en && (a_mread || a_mwrite) && !prev_act && last_resp_cyc >= 0)
      chk("a.reassert_gap", 64'(cyc - last_resp_cyc), 64'd2);
    prev_act = a_mread || a_mwrite;
    if (|a_resp) begin
      last_resp_cyc = cyc;
      a_order.push_back(int'(a_gid));
    end
    if (a_mread) a_mrd_cnt++;
    if (|b_resp) b_order.push_back(int'(b_gid));
  end

  // Adaptor responders: answer after a programmable number of busy cycles.
  bit a_auto = 1'b1, b_auto = 1'b1;
  int a_lat = 5, b_lat = 3, a_cnt = 0, b_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      a_cnt = 0;
      if (a_auto) a_memresp = 1'b0;
    end else if (a_auto) begin
      if (a_memresp) begin
        a_memresp = 1'b0;
        a_cnt     = 0;
      end else if (a_mread || a_mwrite) begin
        a_cnt++;
        if (a_cnt >= a_lat) begin
          a_memresp  = 1'b1;
          a_memrdata = {$urandom, $urandom};
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      b_cnt = 0;
      if (b_auto) b_memresp = 1'b0;
    end else if (b_auto) begin
      if (b_memresp) begin
        b_memresp = 1'b0;
        b_cnt     = 0;
      end else if (b_mread || b_mwrite) begin
        b_cnt++;
        if (b_cnt >= b_lat) begin
          b_memresp  = 1'b1;
          b_memrdata = {$urandom, $urandom};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(int d, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((d == 0) ? (|a_resp) : (|b_resp)) return;
    end
    chk((d == 0) ? "a.resp_timeout" : "b.resp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
    $fatal(1);
  end

  int exp_a[5] = '{0, 1, 2, 3, 0};
  int exp_b[4] = '{0, 0, 0, 1};

  initial begin
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0;
    a_memresp = 1'b0; a_memrdata = '1;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    b_memresp = 1'b0; b_memrdata = '1;

    // Reset values.
    @(negedge clk);
    chk("a.rst_mem_read", 64'(a_mread), 64'd0);
    chk("a.rst_mem_write", 64'(a_mwrite), 64'd0);
    chk("a.rst_mem_addr", 64'(a_maddr), 64'd0);
    chk("a.rst_mem_wdata", a_mwdata, 64'd0);
    chk("a.rst_cl_resp", 64'(a_resp), 64'd0);
    chk("a.rst_cl_rdata", a_rdata, 64'd0);
    chk("a.rst_grant_valid", 64'(a_gv), 64'd0);
    chk("a.rst_grant_id", 64'(a_gid), 64'd0);
    chk("b.rst_grant_id", 64'(b_gid), 64'd0);
    chk("b.rst_mem_read", 64'(b_mread), 64'd0);
    tick();
    rst = 1'b0;

    // Single read from client 1, memory answers in the 5th busy cycle.
    a_mrd_cnt = 0;
    a_lat = 5;
    a_addr[1] = 32'h0000_1000;
    a_read[1] = 1'b1;
    wait_resp(0, 20);
    chk("a.single_grant_id", 64'(a_gid), 64'd1);
    chk("a.single_cl_resp", 64'(a_resp), 64'h2);
    chk("a.single_cl_rdata", a_rdata, a_memrdata);
    chk("a.single_mem_addr", 64'(a_maddr), 64'h1000);
    tick();
    a_read[1] = 1'b0;
    chk("a.single_read_cycles", 64'(a_mrd_cnt), 64'd5);

    // Write latch: later client changes must not reach mem_wdata/mem_addr.
    a_lat = 4;
    a_addr[0]  = 32'h80;
    a_wdata[0] = {8{8'hA5}};
    a_write[0] = 1'b1;
    tick();
    tick();
    a_wdata[0] = {8{8'h5A}};
    a_addr[0]  = 32'hFFF0;
    wait_resp(0, 20);
    chk("a.wlatch_mem_wdata", a_mwdata, {8{8'hA5}});
    chk("a.wlatch_mem_addr", 64'(a_maddr), 64'h80);
    chk("a.wlatch_mem_write", 64'(a_mwrite), 64'd1);
    tick();
    a_write[0] = 1'b0;
    tick();

    // Read and write together is taken as a write.
    a_lat = 2;
    a_addr[2]  = 32'h2040;
    a_wdata[2] = 64'h0123_4567_89AB_CDEF;
    a_read[2]  = 1'b1;
    a_write[2] = 1'b1;
    wait_resp(0, 20);
    chk("a.rw_mem_write", 64'(a_mwrite), 64'd1);
    chk("a.rw_mem_read", 64'(a_mread), 64'd0);
    chk("a.rw_grant_id", 64'(a_gid), 64'd2);
    tick();
    a_read[2]  = 1'b0;
    a_write[2] = 1'b0;
    tick();

    // Round-robin fairness from reset, all four clients requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) a_addr[i] = 32'(32'h100 * (i + 1));
    a_order.delete();
    last_resp_cyc = -1;
    gap_en = 1'b1;
    a_read = 4'hF;
    for (int i = 0; i < 5; i++) wait_resp(0, 20);
    tick();
    a_read = '0;
    gap_en = 1'b0;
    chk("a.rr_order_len", 64'(a_order.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < a_order.size()) chk($sformatf("a.rr_order[%0d]", i), 64'(a_order[i]), 64'(exp_a[i]));
    tick();

    // Asynchronous reset while a response is being delivered.
    a_auto = 1'b0;
    a_addr[1] = 32'h3000;
    a_read[1] = 1'b1;
    tick();
    tick();
    a_memrdata = 64'hDEAD_BEEF_0000_1111;
    a_memresp  = 1'b1;
    #1;
    chk("a.pre_rst_cl_resp", 64'(a_resp), 64'h2);
    chk("a.pre_rst_mem_read", 64'(a_mread), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("a.async_rst_mem_read", 64'(a_mread), 64'd0);
    chk("a.async_rst_grant_valid", 64'(a_gv), 64'd0);
    chk("a.async_rst_cl_resp", 64'(a_resp), 64'd0);
    chk("a.async_rst_cl_rdata", a_rdata, 64'd0);
    tick();
    rst = 1'b0;
    a_memresp = 1'b0;
    a_read[1] = 1'b0;
    tick();

    // Spurious mem_resp in IDLE: no response, pointer still favours client 0.
    a_memresp = 1'b1;
    #1;
    chk("a.spurious_cl_resp", 64'(a_resp), 64'd0);
    chk("a.spurious_grant_valid", 64'(a_gv), 64'd0);
    tick();
    a_memresp = 1'b0;
    a_auto = 1'b1;
    a_lat = 1;
    a_read[0] = 1'b1;
    a_read[3] = 1'b1;
    wait_resp(0, 20);
    chk("a.post_rst_first_grant", 64'(a_gid), 64'd0);
    tick();
    a_read[0] = 1'b0;
    wait_resp(0, 20);
    chk("a.post_rst_second_grant", 64'(a_gid), 64'd3);
    tick();
    a_read[3] = 1'b0;
    tick();

    // Fixed priority: client 0 keeps winning until it stops requesting.
    b_order.delete();
    b_addr[0]  = 32'h4000;
    b_addr[1]  = 32'h5000;
    b_wdata[1] = 64'hCAFE_F00D_1234_5678;
    b_read[0]  = 1'b1;
    b_write[1] = 1'b1;
    for (int i = 0; i < 3; i++) wait_resp(1, 20);
    tick();
    b_read[0] = 1'b0;
    wait_resp(1, 20);
    chk("b.fp_mem_wdata", b_mwdata, 64'hCAFE_F00D_1234_5678);
    tick();
    b_write[1] = 1'b0;
    chk("b.fp_order_len", 64'(b_order.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < b_order.size()) chk($sformatf("b.fp_order[%0d]", i), 64'(b_order[i]), 64'(exp_b[i]));

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
